// File: rtl/event_arbiter.sv
// event_arbiter: round-robin arbiter that serializes the pending events of a
// bank of trigger_counter instances into a single valid/ready event stream.
//
// Each req_valid bit is a counter's pop_valid. At most one requester is popped
// per cycle through req_pop, and its index is captured in a one-entry output
// register (out_valid/out_idx) for the downstream module driver.
//
// Timing note: req_pop is combinational and depends on out_ready through
// can_accept (!out_valid || out_ready). That gives a combinational path
// out_ready -> req_pop -> trigger_counter pop_ready, which lets the arbiter
// sustain one event per cycle while the output register drains.
//
// Build option: define EVENT_ARBITER_FIXED_PRIO_EN to replace round-robin with
// fixed lowest-index priority. In that build the pointer stays at 0.

module event_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_pop,
    output logic                 out_valid,
    output logic [IDX_WIDTH-1:0] out_idx,
    input  logic                 out_ready,
    output logic [IDX_WIDTH-1:0] rr_ptr_o
);

    // Candidate arithmetic needs one extra bit so the wrap compare against
    // NUM_REQ works even when NUM_REQ == 2**IDX_WIDTH.
    localparam int            CW        = IDX_WIDTH + 1;
    localparam logic [CW-1:0] NUM_REQ_C = CW'(NUM_REQ);

    // Reject requester counts the index width cannot address.
    if ((NUM_REQ < 2) || (NUM_REQ > (2 ** IDX_WIDTH))) begin : g_bad_cfg
        $error("event_arbiter: NUM_REQ=%0d illegal for IDX_WIDTH=%0d", NUM_REQ, IDX_WIDTH);
    end

    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [IDX_WIDTH-1:0] out_idx_q;
    logic [IDX_WIDTH-1:0] out_idx_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q;
    logic [IDX_WIDTH-1:0] rr_ptr_d;

    logic                 can_accept_s;
    logic                 found_s;
    logic [IDX_WIDTH-1:0] winner_s;
    logic                 grant_s;
    logic [CW-1:0]        cand_s;
    logic [NUM_REQ-1:0]   req_pop_s;

    assign can_accept_s = (!out_valid_q) || out_ready;
    assign grant_s      = found_s && can_accept_s;

    // Scan requesters starting at the pointer, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_q} + CW'(k);
            if (cand_s >= NUM_REQ_C) begin
                cand_s = cand_s - NUM_REQ_C;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req_valid[cand_s[IDX_WIDTH-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[IDX_WIDTH-1:0];
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // One-hot pop to the winning counter; forced to zero while in reset.
    always_comb begin
        req_pop_s = '0;
        if (grant_s && rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (winner_s == IDX_WIDTH'(i)) begin
                    req_pop_s[i] = 1'b1;
                end else begin
                    req_pop_s[i] = 1'b0;
                end
            end
        end else begin
            req_pop_s = '0;
        end
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
`ifdef EVENT_ARBITER_FIXED_PRIO_EN
        rr_ptr_d    = '0;
`else
        rr_ptr_d    = rr_ptr_q;
`endif
        if (grant_s) begin
            // A grant also covers the simultaneous-drain case: new event replaces old.
            out_valid_d = 1'b1;
            out_idx_d   = winner_s;
`ifndef EVENT_ARBITER_FIXED_PRIO_EN
            if (winner_s == IDX_WIDTH'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner_s + IDX_WIDTH'(1);
            end
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; asynchronous reset drops any held event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign req_pop   = req_pop_s;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Directed bench for event_arbiter (default round-robin build). A second
// instance with NUM_REQ=3 covers the non-power-of-two wrap.
module tb_event_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_pop;
    logic       out_valid;
    logic [1:0] out_idx;
    logic       out_ready;
    logic [1:0] rr_ptr;

    logic [2:0] req_valid3;
    logic [2:0] req_pop3;
    logic       out_valid3;
    logic [1:0] out_idx3;
    logic       out_ready3;
    logic [1:0] rr_ptr3;

    int checks = 0;
    int errors = 0;

    int         cnt0;
    int         cnt1;
    int         exp_order [0:3];
    logic [3:0] pop_cap;

    event_arbiter #(.NUM_REQ(4), .IDX_WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_pop   (req_pop),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .rr_ptr_o  (rr_ptr)
    );

    event_arbiter #(.NUM_REQ(3), .IDX_WIDTH(2)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid3),
        .req_pop   (req_pop3),
        .out_valid (out_valid3),
        .out_idx   (out_idx3),
        .out_ready (out_ready3),
        .rr_ptr_o  (rr_ptr3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 0;
        exp_order[3] = 0;

        // Reset held with all requests pending
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        out_ready  = 1'b1;
        req_valid3 = 3'b000;
        out_ready3 = 1'b1;
        #2;
        chk("rst_pop",    32'(req_pop),   32'h0);
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_rr",     32'(rr_ptr),    32'h0);
        chk("rst_idx",    32'(out_idx),   32'h0);
        tick();
        chk("rst_pop_edge",   32'(req_pop),   32'h0);
        chk("rst_valid_edge", 32'(out_valid), 32'h0);

        // Release reset: round-robin 0,1,2,3,0,1,2,3
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_pop", 32'(req_pop), 32'h1 << (i % 4));
            tick();
            chk("rr_idx",   32'(out_idx),   32'(i % 4));
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_ptr",   32'(rr_ptr),    32'((i + 1) % 4));
        end

        // Backpressure: park index 2, then stall with 1011 pending
        req_valid = 4'b0100;
        #1;
        chk("bp_setup_pop", 32'(req_pop), 32'h4);
        tick();
        chk("bp_setup_idx", 32'(out_idx), 32'h2);
        out_ready = 1'b0;
        req_valid = 4'b1011;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("bp_pop", 32'(req_pop), 32'h0);
            tick();
            chk("bp_idx",   32'(out_idx),   32'h2);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_rr",    32'(rr_ptr),    32'h3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_pop", 32'(req_pop), 32'h8);
        tick();
        chk("bp_release_idx", 32'(out_idx), 32'h3);
        chk("bp_release_rr",  32'(rr_ptr),  32'h0);

        // Wrap/skip: reach rr=3, then only requester 1 pending
        req_valid = 4'b0100;
        #1;
        tick();
        chk("skip_rr3", 32'(rr_ptr), 32'h3);
        req_valid = 4'b0010;
        #1;
        chk("skip_pop", 32'(req_pop), 32'h2);
        tick();
        chk("skip_idx", 32'(out_idx), 32'h1);
        chk("skip_rr",  32'(rr_ptr),  32'h2);

        // Drain without a new grant: valid drops, index holds
        req_valid = 4'b0000;
        #1;
        chk("drain_pop", 32'(req_pop), 32'h0);
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_idx",   32'(out_idx),   32'h1);
        chk("drain_rr",    32'(rr_ptr),    32'h2);

        // Mid-stream asynchronous reset
        req_valid = 4'b1111;
        #1;
        chk("mid_pop", 32'(req_pop), 32'h4);
        tick();
        chk("mid_idx",   32'(out_idx),   32'h2);
        chk("mid_valid", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_rr",    32'(rr_ptr),    32'h0);
        chk("arst_idx",   32'(out_idx),   32'h0);
        chk("arst_pop",   32'(req_pop),   32'h0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk("post_rst_pop", 32'(req_pop), 32'h0);

        // Integration with two modelled counters: counts 3 and 1 -> order 0,1,0,0
        cnt0 = 3;
        cnt1 = 1;
        for (int k = 0; k < 4; k++) begin
            req_valid = {2'b00, (cnt1 > 0), (cnt0 > 0)};
            #1;
            pop_cap = req_pop;
            chk("int_pop", 32'(pop_cap), 32'h1 << exp_order[k]);
            tick();
            chk("int_idx", 32'(out_idx), 32'(exp_order[k]));
            if (pop_cap[0]) cnt0--;
            if (pop_cap[1]) cnt1--;
        end
        req_valid = {2'b00, (cnt1 > 0), (cnt0 > 0)};
        #1;
        chk("int_cnt0",  32'(cnt0),      32'h0);
        chk("int_cnt1",  32'(cnt1),      32'h0);
        chk("int_valid", 32'(req_valid), 32'h0);
        chk("int_pop_0", 32'(req_pop),   32'h0);

        // NUM_REQ=3 instance: rr=2 grant 2 wraps to 0
        req_valid3 = 3'b010;
        #1;
        chk("n3_pop1", 32'(req_pop3), 32'h2);
        tick();
        chk("n3_idx1", 32'(out_idx3), 32'h1);
        chk("n3_rr1",  32'(rr_ptr3),  32'h2);
        req_valid3 = 3'b101;
        #1;
        chk("n3_pop2", 32'(req_pop3), 32'h4);
        tick();
        chk("n3_idx2", 32'(out_idx3), 32'h2);
        chk("n3_rr2",  32'(rr_ptr3),  32'h0);
        req_valid3 = 3'b111;
        #1;
        chk("n3_pop3", 32'(req_pop3), 32'h1);
        tick();
        chk("n3_idx3", 32'(out_idx3), 32'h0);
        chk("n3_rr3",  32'(rr_ptr3),  32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
